// File: rtl/cpu_csr_unit_pkg.sv
// rtl/cpu_csr_unit_pkg.sv - op codes, CSR addresses and FSM states for the CSR controller
package cpu_csr_unit_pkg;

    // Op codes presented by the execute stage
    localparam logic [2:0] CSR_OP_RW   = 3'd1;
    localparam logic [2:0] CSR_OP_RS   = 3'd2;
    localparam logic [2:0] CSR_OP_RC   = 3'd3;
    localparam logic [2:0] CSR_OP_TRAP = 3'd4;
    localparam logic [2:0] CSR_OP_MRET = 3'd5;

    // CSRs backed by the downstream CSR file
    localparam logic [11:0] CSR_ADDR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCYCLE = 12'hB00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_TRAP  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic csr_is_rmw(input logic [2:0] op);
        return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
    endfunction

    function automatic logic csr_is_implemented(input logic [11:0] addr);
        return (addr == CSR_ADDR_MTVEC) || (addr == CSR_ADDR_MEPC) ||
               (addr == CSR_ADDR_MCYCLE);
    endfunction

endpackage

// File: rtl/cpu_csr_alu.sv
// rtl/cpu_csr_alu.sv - new-value computation for Zicsr read-modify-write ops
module cpu_csr_alu
    import cpu_csr_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    output logic [31:0] new_o
);

    // Value written back: replace, set bits, or clear bits of the old value
    always_comb begin
        new_o = old_i;
        case (op_i)
            CSR_OP_RW: new_o = src_i;
            CSR_OP_RS: new_o = old_i | src_i;
            CSR_OP_RC: new_o = old_i & ~src_i;
            default:   new_o = old_i;
        endcase
    end

endmodule

// File: rtl/cpu_csr_unit.sv
// rtl/cpu_csr_unit.sv - multicycle CSR controller: Zicsr ops, trap entry and MRET
module cpu_csr_unit
    import cpu_csr_unit_pkg::*;
#(
    parameter int unsigned MCYCLE_WRITABLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_csr,
    input  logic [31:0] req_src,
    input  logic        req_src_zero,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_redirect,
    output logic [31:0] resp_target,
    output logic        resp_illegal,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        csr_wenable
);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [11:0] csr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [31:0] old_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_redirect_q;
    logic [31:0] resp_target_q;
    logic        resp_illegal_q;
    logic [11:0] csr_raddr_q;
    logic [11:0] csr_waddr_q;
    logic [31:0] csr_wdata_q;
    logic        csr_wenable_q;

    logic        illegal_d;
    logic [31:0] wdata_d;

    // Decide at acceptance whether the incoming request can be executed at all
    always_comb begin
        illegal_d = 1'b0;
        if (csr_is_rmw(req_op)) begin
            if (!csr_is_implemented(req_csr)) begin
                illegal_d = 1'b1;
            end else if ((req_csr == CSR_ADDR_MCYCLE) && (MCYCLE_WRITABLE == 0) &&
                         ((req_op == CSR_OP_RW) || !req_src_zero)) begin
                // mcycle stays readable; only an op that would actually write it is rejected
                illegal_d = 1'b1;
            end
        end else if ((req_op != CSR_OP_TRAP) && (req_op != CSR_OP_MRET)) begin
            illegal_d = 1'b1;
        end
    end

    cpu_csr_alu u_alu (
        .op_i  (op_q),
        .old_i (csr_rdata),
        .src_i (src_q),
        .new_o (wdata_d)
    );

    // Control FSM; every CSR-port and response output is a flop set on the edge entering its cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            op_q            <= 3'd0;
            csr_q           <= 12'd0;
            src_q           <= 32'd0;
            src_zero_q      <= 1'b0;
            old_q           <= 32'd0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_redirect_q <= 1'b0;
            resp_target_q   <= 32'd0;
            resp_illegal_q  <= 1'b0;
            csr_raddr_q     <= 12'd0;
            csr_waddr_q     <= 12'd0;
            csr_wdata_q     <= 32'd0;
            csr_wenable_q   <= 1'b0;
        end else begin
            // CSR ports are only meaningful for a single cycle; park them at zero otherwise
            csr_wenable_q <= 1'b0;
            csr_raddr_q   <= 12'd0;
            csr_waddr_q   <= 12'd0;
            csr_wdata_q   <= 32'd0;

            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        csr_q      <= req_csr;
                        src_q      <= req_src;
                        src_zero_q <= req_src_zero;
                        if (illegal_d) begin
                            state_q        <= ST_RESP;
                            resp_valid_q   <= 1'b1;
                            resp_illegal_q <= 1'b1;
                        end else if (req_op == CSR_OP_TRAP) begin
                            // Save the PC and fetch the handler base in the same cycle
                            state_q       <= ST_TRAP;
                            csr_wenable_q <= 1'b1;
                            csr_waddr_q   <= CSR_ADDR_MEPC;
                            csr_wdata_q   <= req_pc & ~32'h3;
                            csr_raddr_q   <= CSR_ADDR_MTVEC;
                        end else if (req_op == CSR_OP_MRET) begin
                            state_q     <= ST_READ;
                            csr_raddr_q <= CSR_ADDR_MEPC;
                        end else begin
                            state_q     <= ST_READ;
                            csr_raddr_q <= req_csr;
                        end
                    end
                end

                ST_READ: begin
                    if (op_q == CSR_OP_MRET) begin
                        state_q         <= ST_RESP;
                        resp_valid_q    <= 1'b1;
                        resp_redirect_q <= 1'b1;
                        resp_target_q   <= csr_rdata & ~32'h3;
                    end else begin
                        state_q <= ST_WRITE;
                        old_q   <= csr_rdata;
                        // Set/clear with a zero source must not touch the CSR (side effects)
                        if ((op_q == CSR_OP_RW) || !src_zero_q) begin
                            csr_wenable_q <= 1'b1;
                            csr_waddr_q   <= csr_q;
                            csr_wdata_q   <= wdata_d;
                        end
                    end
                end

                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= old_q;
                end

                ST_TRAP: begin
                    state_q         <= ST_RESP;
                    resp_valid_q    <= 1'b1;
                    resp_redirect_q <= 1'b1;
                    resp_target_q   <= csr_rdata & ~32'h3;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q         <= ST_IDLE;
                        resp_valid_q    <= 1'b0;
                        resp_rdata_q    <= 32'd0;
                        resp_redirect_q <= 1'b0;
                        resp_target_q   <= 32'd0;
                        resp_illegal_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_redirect = resp_redirect_q;
    assign resp_target   = resp_target_q;
    assign resp_illegal  = resp_illegal_q;
    assign csr_raddr     = csr_raddr_q;
    assign csr_waddr     = csr_waddr_q;
    assign csr_wdata     = csr_wdata_q;
    assign csr_wenable   = csr_wenable_q;

endmodule

// File: tb/tb_cpu_csr_unit.sv
// tb/tb_cpu_csr_unit.sv - scoreboard bench for cpu_csr_unit with a behavioural CSR model
module tb_cpu_csr_unit;

    localparam logic [2:0]  OP_RW = 3'd1, OP_RS = 3'd2, OP_RC = 3'd3;
    localparam logic [2:0]  OP_TRAP = 3'd4, OP_MRET = 3'd5;
    localparam logic [11:0] A_MTVEC = 12'h305, A_MEPC = 12'h341, A_MCYCLE = 12'hB00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [11:0] req_csr = 12'd0;
    logic [31:0] req_src = 32'd0;
    logic        req_src_zero = 1'b0;
    logic [31:0] req_pc = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_redirect;
    logic [31:0] resp_target;
    logic        resp_illegal;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wenable;

    cpu_csr_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_csr       (req_csr),
        .req_src       (req_src),
        .req_src_zero  (req_src_zero),
        .req_pc        (req_pc),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_redirect (resp_redirect),
        .resp_target   (resp_target),
        .resp_illegal  (resp_illegal),
        .csr_raddr     (csr_raddr),
        .csr_rdata     (csr_rdata),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .csr_wenable   (csr_wenable)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in CSR file: combinational read, write on the clock edge, free-running mcycle
    logic [31:0] f_mtvec  = 32'h0000_0100;
    logic [31:0] f_mepc   = 32'h0000_0000;
    logic [31:0] f_mcycle = 32'h0000_1000;

    always_comb begin
        case (csr_raddr)
            A_MTVEC:  csr_rdata = f_mtvec;
            A_MEPC:   csr_rdata = f_mepc;
            A_MCYCLE: csr_rdata = f_mcycle;
            default:  csr_rdata = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        f_mcycle <= f_mcycle + 32'd1;
        if (csr_wenable) begin
            case (csr_waddr)
                A_MTVEC:  f_mtvec  <= csr_wdata;
                A_MEPC:   f_mepc   <= csr_wdata;
                A_MCYCLE: f_mcycle <= csr_wdata;
                default:  ;
            endcase
        end
    end

    // Reference model: architectural CSR contents, mcycle as base + elapsed cycles
    logic [31:0] m_mtvec   = 32'h0000_0100;
    logic [31:0] m_mepc    = 32'h0000_0000;
    logic [31:0] m_mc_base = 32'h0000_1000;
    int unsigned m_mc_cyc  = 0;

    function automatic logic [31:0] m_read(input logic [11:0] a, input int unsigned k);
        if (a == A_MTVEC) return m_mtvec;
        if (a == A_MEPC)  return m_mepc;
        return m_mc_base + (k - m_mc_cyc);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] tgt;
        logic        ill;
        logic        chk_rdata;
        logic        chk_tgt;
        int unsigned cyc;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } wr_t;

    resp_t exp_resp[$];
    wr_t   exp_wr[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s actual=0x%08h required=0x%08h", name, got, exp);
    endfunction

    // Issue one request; returns one cycle after the accepting edge
    task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                         input logic sz, input logic [31:0] pc);
        int          waited;
        int unsigned c;
        logic [31:0] old_v;
        logic [31:0] new_v;
        resp_t       r;
        wr_t         w;
        req_op = op; req_csr = csr; req_src = src; req_src_zero = sz; req_pc = pc;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL ready_timeout req_ready=%0b required=1", req_ready);
            req_valid = 1'b0;
            return;
        end
        c = cyc;
        r.rdata = 32'd0; r.redir = 1'b0; r.tgt = 32'd0; r.ill = 1'b0;
        r.chk_rdata = 1'b0; r.chk_tgt = 1'b0; r.cyc = 0;
        if (op == OP_RW || op == OP_RS || op == OP_RC) begin
            if (csr == A_MTVEC || csr == A_MEPC || csr == A_MCYCLE) begin
                old_v = m_read(csr, c + 1);
                if (op == OP_RW)      new_v = src;
                else if (op == OP_RS) new_v = old_v | src;
                else                  new_v = old_v & ~src;
                if (op == OP_RW || !sz) begin
                    w.addr = csr; w.data = new_v; w.cyc = c + 2;
                    exp_wr.push_back(w);
                    if (csr == A_MTVEC)     m_mtvec = new_v;
                    else if (csr == A_MEPC) m_mepc  = new_v;
                    else begin
                        m_mc_base = new_v;
                        m_mc_cyc  = c + 3;
                    end
                end
                r.rdata = old_v; r.chk_rdata = 1'b1; r.cyc = c + 3;
            end else begin
                r.ill = 1'b1; r.chk_rdata = 1'b1; r.cyc = c + 1;
            end
        end else if (op == OP_TRAP) begin
            w.addr = A_MEPC; w.data = {pc[31:2], 2'b00}; w.cyc = c + 1;
            exp_wr.push_back(w);
            m_mepc  = {pc[31:2], 2'b00};
            r.redir = 1'b1; r.tgt = {m_mtvec[31:2], 2'b00}; r.chk_tgt = 1'b1; r.cyc = c + 2;
        end else if (op == OP_MRET) begin
            r.redir = 1'b1; r.tgt = {m_mepc[31:2], 2'b00}; r.chk_tgt = 1'b1; r.cyc = c + 2;
        end else begin
            r.ill = 1'b1; r.chk_rdata = 1'b1; r.cyc = c + 1;
        end
        exp_resp.push_back(r);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_redirect", resp_redirect, 0);
        chk("rst_resp_target", resp_target, 0);
        chk("rst_resp_illegal", resp_illegal, 0);
        chk("rst_csr_wenable", csr_wenable, 0);
        chk("rst_csr_raddr", csr_raddr, 0);
        chk("rst_csr_waddr", csr_waddr, 0);
        chk("rst_csr_wdata", csr_wdata, 0);
    endtask

    // Consumer back-pressure: forced stall window, otherwise mostly ready
    int hold_left = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (hold_left > 0) begin
                resp_ready = 1'b0;
                if (resp_valid) hold_left--;
            end else begin
                resp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Write monitor: every strobe must match the next expected write in address, data and cycle
    always @(negedge clk) begin
        wr_t w;
        if (csr_wenable) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write waddr=0x%03h wdata=0x%08h required=no write",
                         csr_waddr, csr_wdata);
            end else begin
                w = exp_wr.pop_front();
                chk("write_addr", csr_waddr, w.addr);
                chk("write_data", csr_wdata, w.data);
                chk("write_cycle", cyc, w.cyc);
            end
        end
    end

    // Response monitor: pop on the first RESP cycle, recheck the same expectation while stalled
    logic  in_resp = 1'b0;
    logic  cur_ok = 1'b0;
    resp_t cur;
    int    run = 0;
    int    max_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            in_resp = 1'b0;
        end else if (resp_valid) begin
            if (!in_resp) begin
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    cur_ok = 1'b0;
                    $display("FAIL unexpected_resp rdata=0x%08h illegal=%0b required=no response",
                             resp_rdata, resp_illegal);
                end else begin
                    cur = exp_resp.pop_front();
                    cur_ok = 1'b1;
                    chk("resp_cycle", cyc, cur.cyc);
                end
                in_resp = 1'b1;
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
            end
            if (cur_ok) begin
                chk("resp_illegal", resp_illegal, cur.ill);
                chk("resp_redirect", resp_redirect, cur.redir);
                if (cur.chk_rdata) chk("resp_rdata", resp_rdata, cur.rdata);
                if (cur.chk_tgt)   chk("resp_target", resp_target, cur.tgt);
            end
            chk("req_ready_in_resp", req_ready, 0);
            if (resp_ready) in_resp = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_mepc;
        logic [2:0]  op;
        logic [11:0] csr;
        logic [31:0] src;
        logic        sz;
        int          sel;
        int          waited;

        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        issue(OP_RW, A_MTVEC, 32'h8000_0004, 1'b0, 32'd0);
        issue(OP_RS, A_MTVEC, 32'd0, 1'b1, 32'd0);
        issue(OP_RW, A_MEPC, 32'hF0F0_0000, 1'b0, 32'd0);
        issue(OP_RS, A_MEPC, 32'h0000_00FF, 1'b0, 32'd0);
        issue(OP_RS, A_MEPC, 32'd0, 1'b1, 32'd0);
        issue(OP_RC, A_MEPC, 32'hF000_0000, 1'b0, 32'd0);
        issue(OP_RS, A_MEPC, 32'd0, 1'b1, 32'd0);
        issue(OP_RW, A_MTVEC, 32'h0000_0203, 1'b0, 32'd0);
        issue(OP_TRAP, 12'd0, 32'd0, 1'b0, 32'h0000_1006);
        issue(OP_MRET, 12'd0, 32'd0, 1'b0, 32'd0);
        issue(OP_RW, 12'h300, 32'h1234_5678, 1'b0, 32'd0);
        issue(3'd0, A_MEPC, 32'd1, 1'b0, 32'd0);
        issue(3'd6, A_MEPC, 32'd1, 1'b0, 32'd0);
        issue(3'd7, A_MEPC, 32'd1, 1'b0, 32'd0);
        issue(OP_RS, A_MCYCLE, 32'd0, 1'b1, 32'd0);
        issue(OP_RW, A_MCYCLE, 32'h0000_5000, 1'b0, 32'd0);
        issue(OP_RS, A_MCYCLE, 32'd0, 1'b1, 32'd0);

        hold_left = 5;
        issue(OP_RW, A_MTVEC, 32'h0000_0400, 1'b0, 32'd0);

        // Abort a read-modify-write in its WRITE cycle
        saved_mepc = m_mepc;
        issue(OP_RW, A_MEPC, 32'h1234_5678, 1'b0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_wr.delete();
        exp_resp.delete();
        m_mepc = saved_mepc;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1);
        rst = 1'b0;
        issue(OP_RS, A_MEPC, 32'd0, 1'b1, 32'd0);

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            sz  = ($urandom_range(0, 3) == 0);
            src = sz ? 32'd0 : $urandom;
            case ($urandom_range(0, 4))
                0:       csr = A_MTVEC;
                1:       csr = A_MEPC;
                2:       csr = A_MCYCLE;
                3:       csr = 12'($urandom);
                default: csr = A_MEPC;
            endcase
            if (sel <= 5)      op = 3'($urandom_range(1, 3));
            else if (sel <= 7) op = OP_TRAP;
            else if (sel == 8) op = OP_MRET;
            else begin
                case ($urandom_range(0, 2))
                    0:       op = 3'd0;
                    1:       op = 3'd6;
                    default: op = 3'd7;
                endcase
            end
            issue(op, csr, src, sz, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        waited = 0;
        while ((exp_resp.size() != 0 || in_resp) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("resp_queue_drained", exp_resp.size(), 0);
        chk("write_queue_drained", exp_wr.size(), 0);
        chk("stall_held_5_cycles", (max_run >= 4), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
